// File: rtl/oled_pkg.sv
// Shared definitions for the OLED byte responder.
// Holds the init command bytes, the D/C levels, the controller state
// encoding and a lookup for the command list sent after the panel supply
// comes up.
package oled_pkg;

  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_CHG_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_CHG_PUMP_EN = 8'h14;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [3:0] {
    PWR_VDD,
    RST_LO,
    RST_HI,
    CMD0,
    PWR_VBAT,
    CMD1,
    READY,
    XFER,
    ACK
  } state_t;

  // Commands sent once the panel supply is on, in order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_CHG_PUMP;
      2'd1:    return CMD_CHG_PUMP_EN;
      default: return CMD_DISP_ON;
    endcase
  endfunction

endpackage

// File: rtl/oled_byte_responder_if.sv
// Byte handshake between the display-string sender (master) and the OLED
// responder (slave). 4-phase: master raises sendDataValid with sendData,
// slave raises sendDone when the byte is out, master drops valid, slave
// drops sendDone.
//   sendData      : byte offered by the master
//   sendDataValid : request from the master
//   sendDone      : completion, held until sendDataValid falls
interface oled_byte_responder_if;
  logic [7:0] sendData;
  logic       sendDataValid;
  logic       sendDone;

  modport master (output sendData, output sendDataValid, input sendDone);
  modport slave  (input sendData, input sendDataValid, output sendDone);
endinterface

// File: rtl/oled_byte_responder_spi_byte_tx.sv
// SPI mode-3 byte serialiser, MSB first.
//   clock, reset : system clock, synchronous active-high reset
//   start        : load byte_in and begin shifting (ignored while busy)
//   byte_in      : byte to send
//   sclk, mosi   : SPI clock (idles high) and data (holds last bit)
//   busy         : a byte is in flight
//   done         : one-cycle pulse after the last high half-period
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] half_cnt;
  logic [2:0]    bits_left;
  logic [6:0]    shreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      half_cnt  <= '0;
      bits_left <= '0;
      shreg     <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          // SCK falls together with the first data bit.
          busy      <= 1'b1;
          sclk      <= 1'b0;
          mosi      <= byte_in[7];
          shreg     <= byte_in[6:0];
          bits_left <= 3'd7;
          half_cnt  <= HALF_LAST;
        end
      end else if (half_cnt != '0) begin
        half_cnt <= half_cnt - 1'b1;
      end else if (!sclk) begin
        sclk     <= 1'b1;
        half_cnt <= HALF_LAST;
      end else if (bits_left == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        sclk      <= 1'b0;
        mosi      <= shreg[6];
        shreg     <= {shreg[5:0], 1'b0};
        bits_left <= bits_left - 1'b1;
        half_cnt  <= HALF_LAST;
      end
    end
  end

endmodule

// File: rtl/oled_byte_responder.sv
// OLED responder: runs the panel power-up sequence and init command list,
// then serialises one display-RAM data byte per handshake over SPI.
//   clock, reset  : system clock, synchronous active-high reset
//   bus           : sendData / sendDataValid / sendDone handshake (slave)
//   ready         : init sequence complete
//   oled_spi_clk  : SCK, idles high
//   oled_spi_data : MOSI, MSB first
//   oled_dc_n     : 0 command, 1 data
//   oled_vdd      : logic supply enable, active low
//   oled_vbat     : panel supply enable, active low
//   oled_reset_n  : panel reset, active low
module oled_byte_responder
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 5,
  parameter int unsigned RESET_PULSE_CYC = 1000,
  parameter int unsigned STARTUP_CYC     = 10_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  oled_byte_responder_if.slave         bus,
  output logic                         ready,
  output logic                         oled_spi_clk,
  output logic                         oled_spi_data,
  output logic                         oled_dc_n,
  output logic                         oled_vdd,
  output logic                         oled_vbat,
  output logic                         oled_reset_n
);

  localparam int unsigned XFER_CYC = 16 * CLK_DIV;
  localparam int unsigned MAX_A    = (STARTUP_CYC > RESET_PULSE_CYC) ? STARTUP_CYC : RESET_PULSE_CYC;
  localparam int unsigned MAX_CYC  = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
  localparam int unsigned CNT_W    = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_PULSE_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       cmd_idx, cmd_idx_n;
  logic             issued, issued_n;
  logic             start_q, start_n;
  logic [7:0]       byte_q, byte_n;
  logic             dc_n_n, done_n, ready_n, vdd_n, vbat_n, rst_n_n;
  logic             tx_busy, tx_done;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clock   (clock),
    .reset   (reset),
    .start   (start_q),
    .byte_in (byte_q),
    .sclk    (oled_spi_clk),
    .mosi    (oled_spi_data),
    .busy    (tx_busy),
    .done    (tx_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PWR_VDD;
      cnt          <= STARTUP_LAST;
      cmd_idx      <= '0;
      issued       <= 1'b0;
      start_q      <= 1'b0;
      byte_q       <= '0;
      oled_dc_n    <= DC_CMD;
      bus.sendDone <= 1'b0;
      ready        <= 1'b0;
      oled_vdd     <= 1'b1;
      oled_vbat    <= 1'b1;
      oled_reset_n <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cmd_idx      <= cmd_idx_n;
      issued       <= issued_n;
      start_q      <= start_n;
      byte_q       <= byte_n;
      oled_dc_n    <= dc_n_n;
      bus.sendDone <= done_n;
      ready        <= ready_n;
      oled_vdd     <= vdd_n;
      oled_vbat    <= vbat_n;
      oled_reset_n <= rst_n_n;
    end
  end

  // Outputs are registered from the next-state values so every pin changes
  // on the same edge as the state it belongs to.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cmd_idx_n = cmd_idx;
    issued_n  = issued;
    start_n   = 1'b0;
    byte_n    = byte_q;
    dc_n_n    = oled_dc_n;
    done_n    = bus.sendDone;
    ready_n   = ready;
    vdd_n     = oled_vdd;
    vbat_n    = oled_vbat;
    rst_n_n   = oled_reset_n;

    case (state)
      PWR_VDD: begin
        vdd_n = 1'b0;
        if (cnt == '0) begin
          state_n = RST_LO;
          rst_n_n = 1'b0;
          cnt_n   = RESET_LAST;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RST_LO: begin
        if (cnt == '0) begin
          state_n = RST_HI;
          rst_n_n = 1'b1;
          cnt_n   = RESET_LAST;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RST_HI: begin
        if (cnt == '0) state_n = CMD0;
        else           cnt_n   = cnt - 1'b1;
      end
      CMD0: begin
        if (!issued && !tx_busy) begin
          start_n  = 1'b1;
          byte_n   = CMD_DISP_OFF;
          dc_n_n   = DC_CMD;
          issued_n = 1'b1;
        end else if (tx_done) begin
          issued_n = 1'b0;
          state_n  = PWR_VBAT;
          vbat_n   = 1'b0;
          cnt_n    = STARTUP_LAST;
        end
      end
      PWR_VBAT: begin
        if (cnt == '0) begin
          state_n   = CMD1;
          cmd_idx_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CMD1: begin
        if (!issued && !tx_busy) begin
          start_n  = 1'b1;
          byte_n   = init_cmd(cmd_idx);
          dc_n_n   = DC_CMD;
          issued_n = 1'b1;
        end else if (tx_done) begin
          issued_n = 1'b0;
          if (cmd_idx == 2'd2) begin
            state_n = READY;
            ready_n = 1'b1;
          end else begin
            cmd_idx_n = cmd_idx + 1'b1;
          end
        end
      end
      READY: begin
        if (bus.sendDataValid && !tx_busy) begin
          start_n = 1'b1;
          byte_n  = bus.sendData;
          dc_n_n  = DC_DATA;
          state_n = XFER;
        end
      end
      XFER: begin
        if (tx_done) begin
          done_n  = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!bus.sendDataValid) begin
          done_n  = 1'b0;
          state_n = READY;
        end
      end
      default: state_n = PWR_VDD;
    endcase
  end

endmodule

// File: tb/tb_oled_byte_responder.sv
// Self-checking bench for oled_byte_responder. An SPI decoder rebuilds each
// byte from MOSI on SCK rising edges and compares {dc_n, byte} against a
// queue of expected bytes filled by the stimulus.
module tb_oled_byte_responder;
  logic clock = 1'b0;
  logic reset;
  logic ready, oled_spi_clk, oled_spi_data, oled_dc_n;
  logic oled_vdd, oled_vbat, oled_reset_n;

  oled_byte_responder_if bus ();

  oled_byte_responder #(
    .CLK_DIV         (2),
    .RESET_PULSE_CYC (4),
    .STARTUP_CYC     (20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .ready         (ready),
    .oled_spi_clk  (oled_spi_clk),
    .oled_spi_data (oled_spi_data),
    .oled_dc_n     (oled_dc_n),
    .oled_vdd      (oled_vdd),
    .oled_vbat     (oled_vbat),
    .oled_reset_n  (oled_reset_n)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  int n_bytes = 0;
  int dec_bits = 0;
  logic [7:0] dec_byte = '0;
  logic sck_prev = 1'b1;
  int done_rises = 0;
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI decoder and sendDone pulse counter.
  always @(negedge clock) begin
    if (reset) begin
      dec_bits = 0;
      sck_prev = 1'b1;
      done_prev = 1'b0;
    end else begin
      if (oled_spi_clk && !sck_prev) begin
        dec_byte = {dec_byte[6:0], oled_spi_data};
        dec_bits++;
        if (dec_bits == 8) begin
          dec_bits = 0;
          n_bytes++;
          if (exp_q.size() == 0) check("spi_extra_byte", 0, 1);
          else check("spi_byte", {oled_dc_n, dec_byte}, exp_q.pop_front());
        end
      end
      sck_prev = oled_spi_clk;
      if (bus.sendDone && !done_prev) done_rises++;
      done_prev = bus.sendDone;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Releases reset and follows the full power-up sequence.
  task automatic power_up(input bit poke_vbat);
    int base, lo, hi_done, i;
    exp_q.push_back({1'b0, 8'hAE});
    exp_q.push_back({1'b0, 8'h8D});
    exp_q.push_back({1'b0, 8'h14});
    exp_q.push_back({1'b0, 8'hAF});
    base = n_bytes;
    reset = 1'b0;
    tick();
    check("vdd_on_cycle1", oled_vdd, 0);
    for (i = 0; i < 100 && oled_reset_n; i++) tick();
    check("rst_lo_seen", oled_reset_n, 0);
    lo = 0;
    for (i = 0; i < 100 && !oled_reset_n; i++) begin
      lo++;
      tick();
    end
    check("rst_pulse_len", lo, 4);
    for (i = 0; i < 500 && oled_vbat; i++) tick();
    check("vbat_on", oled_vbat, 0);
    check("vbat_after_ae", n_bytes - base, 1);
    if (poke_vbat) begin
      bus.sendData = 8'hFF;
      bus.sendDataValid = 1'b1;
      hi_done = 0;
      for (i = 0; i < 5; i++) begin
        tick();
        if (bus.sendDone) hi_done++;
      end
      bus.sendDataValid = 1'b0;
      check("ignore_early_valid", hi_done, 0);
    end
    for (i = 0; i < 1000 && !ready; i++) tick();
    check("ready_up", ready, 1);
    check("init_byte_count", n_bytes - base, 4);
    check("done_idle", bus.sendDone, 0);
  endtask

  // One 4-phase handshake; optionally disturbs sendData mid-byte.
  task automatic send_byte(input logic [7:0] b, input bit scramble);
    int i;
    exp_q.push_back({1'b1, b});
    bus.sendData = b;
    bus.sendDataValid = 1'b1;
    for (i = 0; i < 200 && !bus.sendDone; i++) begin
      tick();
      if (scramble) bus.sendData = ~b;
    end
    check("send_done_seen", bus.sendDone, 1);
    check("sck_idle_ack", oled_spi_clk, 1);
    bus.sendDataValid = 1'b0;
    for (i = 0; i < 20 && bus.sendDone; i++) tick();
    check("send_done_clear", bus.sendDone, 0);
  endtask

  initial begin
    int k, lows, rises0;
    string s;
    s = "00:02:00";
    reset = 1'b1;
    bus.sendData = '0;
    bus.sendDataValid = 1'b0;
    repeat (3) tick();
    check("rst_sendDone", bus.sendDone, 0);
    check("rst_ready", ready, 0);
    check("rst_sck", oled_spi_clk, 1);
    check("rst_mosi", oled_spi_data, 0);
    check("rst_dc", oled_dc_n, 0);
    check("rst_vdd", oled_vdd, 1);
    check("rst_vbat", oled_vbat, 1);
    check("rst_reset_n", oled_reset_n, 1);

    power_up(1'b1);

    // 0x35 with valid held for 60 cycles; latency measured from edge N.
    exp_q.push_back({1'b1, 8'h35});
    bus.sendData = 8'h35;
    bus.sendDataValid = 1'b1;
    for (k = 1; k <= 200; k++) begin
      tick();
      if (bus.sendDone) break;
    end
    check("done_latency", k - 1, 34);
    check("dc_data", oled_dc_n, 1);
    lows = 0;
    for (int j = k; j < 60; j++) begin
      tick();
      if (!bus.sendDone) lows++;
    end
    check("done_hold", lows, 0);
    bus.sendDataValid = 1'b0;
    tick();
    check("done_drop", bus.sendDone, 0);
    check("ready_kept", ready, 1);

    rises0 = done_rises;
    for (int i = 7; i >= 0; i--) begin
      send_byte(s[i], i[0]);
      tick();
      check("sck_idle_gap", oled_spi_clk, 1);
    end
    check("string_done_pulses", done_rises - rises0, 8);

    // Reset after the third bit of 0xA5.
    bus.sendData = 8'hA5;
    bus.sendDataValid = 1'b1;
    for (k = 0; k < 200 && dec_bits != 3; k++) tick();
    check("partial_bits", dec_bits, 3);
    reset = 1'b1;
    tick();
    check("midrst_sck", oled_spi_clk, 1);
    check("midrst_vdd", oled_vdd, 1);
    check("midrst_done", bus.sendDone, 0);
    check("midrst_ready", ready, 0);
    bus.sendDataValid = 1'b0;
    tick();
    power_up(1'b0);
    repeat (40) tick();

    check("queue_empty", exp_q.size(), 0);
    check("total_bytes", n_bytes, 17);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/oled_byte_responder.md
Name: oled_byte_responder

Overview:
- Responder end of the sendData/sendDataValid/sendDone byte handshake driven by the top-level display-string send FSM.
- On reset, runs the OLED power-up sequence and sends a fixed init command list.
- After init, accepts one byte per handshake and shifts it out over SPI as a display-RAM data byte (dc_n=1).
- Character rendering stays upstream. This block only handles power sequencing, SPI serialisation and the handshake.

Parameters:
- CLK_DIV, 5: clock cycles per SPI clock half-period (100 MHz / 10 = 10 MHz SCK).
- RESET_PULSE_CYC, 1000: oled_reset_n low time; also the settle time after reset_n is released.
- STARTUP_CYC, 10_000_000: wait after oled_vdd on, and wait after oled_vbat on.

Ports:
- clock, in, 1: system clock, 100 MHz.
- reset, in, 1: synchronous, active-high reset.
- sendData, in, 8: byte offered by the initiator.
- sendDataValid, in, 1: initiator request (4-phase handshake).
- sendDone, out, 1: byte fully shifted; held high until sendDataValid falls.
- ready, out, 1: high once init is complete.
- oled_spi_clk, out, 1: SCK, idles high (SPI mode 3).
- oled_spi_data, out, 1: MOSI, MSB first.
- oled_dc_n, out, 1: 0 = command, 1 = data.
- oled_vdd, out, 1: logic supply enable, active low.
- oled_vbat, out, 1: panel supply enable, active low.
- oled_reset_n, out, 1: panel reset, active low.

Behaviour:
- Reset values: sendDone=0, ready=0, oled_spi_clk=1, oled_spi_data=0, oled_dc_n=0, oled_vdd=1, oled_vbat=1, oled_reset_n=1. Reset at any time, including mid-byte, returns all outputs to these values at the next edge and restarts from PWR_VDD.
- FSM states and transitions:
  - PWR_VDD: oled_vdd=0, wait STARTUP_CYC → RST_LO.
  - RST_LO: oled_reset_n=0 for RESET_PULSE_CYC → RST_HI.
  - RST_HI: oled_reset_n=1, wait RESET_PULSE_CYC → CMD0.
  - CMD0: send 0xAE (dc_n=0) → PWR_VBAT.
  - PWR_VBAT: oled_vbat=0, wait STARTUP_CYC → CMD1.
  - CMD1: send 0x8D, 0x14, 0xAF in order (dc_n=0) → READY.
  - READY: ready=1; if sendDataValid=1 at edge N, latch sendData, dc_n=1, start the shifter → XFER.
  - XFER: on shifter done, sendDone=1 → ACK.
  - ACK: sendDone held at 1 while sendDataValid=1. The first edge that samples sendDataValid=0 clears sendDone and returns to READY.
- Shifter timing, per bit:
  - SCK falls and the data bit changes together, SCK stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - 8 bits take 16*CLK_DIV cycles; the shifter "done" is a one-cycle pulse after the last high half.
- Latency: the first SCK fall is at N+1. sendDone rises exactly 16*CLK_DIV+2 cycles after edge N.
- oled_dc_n and the latched byte are stable for the whole byte. sendData changes while a byte is in flight are ignored.
- sendDataValid is ignored (no latch, sendDone=0) in all states before READY. A valid already high when READY is entered is accepted on the first READY cycle.
- Between bytes, SCK idles high and MOSI holds its last bit.
- Back-to-back: the next byte is accepted only after sendDone has dropped and valid is re-asserted. There is no pipelining.
- Counters use $clog2(max(STARTUP_CYC, RESET_PULSE_CYC, 16*CLK_DIV)) bits, load with the terminal count and count down, with no wrap-around.

Decomposition:
- Shared package (oled_pkg):
  - init command constants: CMD_DISP_OFF=0xAE, CMD_CHG_PUMP=0x8D, CMD_CHG_PUMP_EN=0x14, CMD_DISP_ON=0xAF;
  - FSM state encoding;
  - DC_CMD=0 and DC_DATA=1.
- One sub-module, spi_byte_tx, with ports clock, reset, start, byte_in[7:0], sclk, mosi, busy and done pulse. The parent FSM sequences it.

Test Plan (CLK_DIV=2, RESET_PULSE_CYC=4, STARTUP_CYC=20 unless noted):
- Reset asserted 3 cycles → all outputs at the listed reset values; ready=0; sendDone=0.
- Release reset:
  - oled_vdd falls at cycle 1; oled_reset_n is low for exactly 4 cycles;
  - SPI decoder captures 0xAE with dc_n=0, then oled_vbat falls;
  - 20 cycles later the decoder captures 0x8D, 0x14, 0xAF, all with dc_n=0;
  - ready=1 afterwards.
- After ready, offer 0x35 with valid held 60 cycles:
  - MOSI = 0,0,1,1,0,1,0,1 sampled on SCK rising edges, dc_n=1;
  - sendDone rises 34 cycles after valid is sampled, stays high until valid drops, and is 0 one cycle after.
- Pulse valid=1 with 0xFF during PWR_VBAT → sendDone stays 0 and no extra SPI byte appears; the init sequence is unchanged.
- Initiator model sends "00:02:00" characters (8 bytes, last index first) → decoder sees 0x30,0x30,0x3A,0x32,0x30,0x3A,0x30,0x30, exactly 8 sendDone pulses, and SCK idles high between bytes.
- Assert reset when 3 bits of 0xA5 have been shifted → next edge: SCK=1, vdd=1, sendDone=0. After release, the full power-up sequence repeats and no partial byte is completed.
